// File: rtl/nth_band_predictor_pkg.sv
// Shared constants, derived datapath widths and the output saturation helper
// for the LCPLC non-first-band predictor.
package nth_band_predictor_pkg;

  // Alpha is unsigned Q1.(ALPHA_WIDTH-1): one integer bit, the rest fraction.
  function automatic int alpha_frac(input int alpha_width);
    return alpha_width - 1;
  endfunction

  function automatic int diff_width(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int prod_width(input int data_width, input int alpha_width);
    return data_width + alpha_width + 2;
  endfunction

  function automatic int sum_width(input int data_width, input int alpha_width);
    return prod_width(data_width, alpha_width) - alpha_frac(alpha_width) + 1;
  endfunction

  // Clamp to the signed range of a DATA_WIDTH+1 bit two's complement result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int data_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< data_width) - 64'sd1;
    lo = -(64'sd1 <<< data_width);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/nth_band_param_latch.sv
// Holds the per-block {alpha, xmean, xhatmean} set, its full flag and the
// in-block sample counter that decides when the next set may be taken.
module nth_band_param_latch
  import nth_band_predictor_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ALPHA_WIDTH    = 10,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_accept,
  input  logic                   alpha_valid,
  input  logic [ALPHA_WIDTH-1:0] alpha_data,
  input  logic                   xmean_valid,
  input  logic [DATA_WIDTH-1:0]  xmean_data,
  input  logic                   xhatmean_valid,
  input  logic [DATA_WIDTH-1:0]  xhatmean_data,
  output logic                   alpha_ready,
  output logic                   xmean_ready,
  output logic                   xhatmean_ready,
  output logic                   full,
  output logic [ALPHA_WIDTH-1:0] alpha,
  output logic [DATA_WIDTH-1:0]  xmean,
  output logic [DATA_WIDTH-1:0]  xhatmean
);

  logic [BLOCK_SIZE_LOG-1:0] count;
  logic                      last_sample;
  logic                      param_ready;
  logic                      load;

  assign last_sample = sample_accept && (count == {BLOCK_SIZE_LOG{1'b1}});
  // The next set may load in the very cycle the current block's last sample leaves.
  assign param_ready = rst && (!full || last_sample);
  assign load        = param_ready && alpha_valid && xmean_valid && xhatmean_valid;

  assign alpha_ready    = param_ready;
  assign xmean_ready    = param_ready;
  assign xhatmean_ready = param_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (sample_accept) count <= count + BLOCK_SIZE_LOG'(1);
      if (load) full <= 1'b1;
      else if (last_sample) full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      alpha    <= alpha_data;
      xmean    <= xmean_data;
      xhatmean <= xhatmean_data;
    end
  end

endmodule

// File: rtl/nth_band_predictor.sv
// Inter-band prediction alpha*(xhat - xhatmean) + xmean for one non-first
// LCPLC band, as a three-stage valid/ready pipeline.
module nth_band_predictor
  import nth_band_predictor_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ALPHA_WIDTH    = 10,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   xhat_valid,
  output logic                   xhat_ready,
  input  logic [DATA_WIDTH-1:0]  xhat_data,
  input  logic                   xmean_valid,
  output logic                   xmean_ready,
  input  logic [DATA_WIDTH-1:0]  xmean_data,
  input  logic                   xhatmean_valid,
  output logic                   xhatmean_ready,
  input  logic [DATA_WIDTH-1:0]  xhatmean_data,
  input  logic                   alpha_valid,
  output logic                   alpha_ready,
  input  logic [ALPHA_WIDTH-1:0] alpha_data,
  output logic                   prediction_valid,
  input  logic                   prediction_ready,
  output logic [DATA_WIDTH:0]    prediction_data
);

  localparam int ALPHA_FRAC = alpha_frac(ALPHA_WIDTH);
  localparam int DIFF_W     = diff_width(DATA_WIDTH);
  localparam int PROD_W     = prod_width(DATA_WIDTH, ALPHA_WIDTH);
  localparam int SUM_W      = sum_width(DATA_WIDTH, ALPHA_WIDTH);

  logic                   full;
  logic                   advance;
  logic                   sample_accept;
  logic [ALPHA_WIDTH-1:0] alpha_held;
  logic [DATA_WIDTH-1:0]  xmean_held;
  logic [DATA_WIDTH-1:0]  xhatmean_held;

  assign advance       = !prediction_valid || prediction_ready;
  assign xhat_ready    = rst && full && advance;
  assign sample_accept = xhat_valid && xhat_ready;

  nth_band_param_latch #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ALPHA_WIDTH    (ALPHA_WIDTH),
    .BLOCK_SIZE_LOG (BLOCK_SIZE_LOG)
  ) u_param_latch (
    .clk            (clk),
    .rst            (rst),
    .sample_accept  (sample_accept),
    .alpha_valid    (alpha_valid),
    .alpha_data     (alpha_data),
    .xmean_valid    (xmean_valid),
    .xmean_data     (xmean_data),
    .xhatmean_valid (xhatmean_valid),
    .xhatmean_data  (xhatmean_data),
    .alpha_ready    (alpha_ready),
    .xmean_ready    (xmean_ready),
    .xhatmean_ready (xhatmean_ready),
    .full           (full),
    .alpha          (alpha_held),
    .xmean          (xmean_held),
    .xhatmean       (xhatmean_held)
  );

  logic signed [DIFF_W-1:0] diff_p0;
  logic signed [DIFF_W-1:0] diff_p1;
  logic [ALPHA_WIDTH-1:0]   alpha_p1;
  logic [DATA_WIDTH-1:0]    xmean_p1;
  logic                     vld_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [PROD_W-1:0] prod_p2;
  logic [DATA_WIDTH-1:0]    xmean_p2;
  logic                     vld_p2;
  logic signed [SUM_W-1:0]  sum_p2;
  logic [DATA_WIDTH:0]      sat_p2;

  // Stage 1: difference against the reference-band mean, parameters follow the sample.
  assign diff_p0 = $signed({1'b0, xhat_data}) - $signed({1'b0, xhatmean_held});

  // Stage 2: scale by alpha at full precision.
  assign prod_p1 = PROD_W'(diff_p1) * PROD_W'($signed({1'b0, alpha_p1}));

  // Stage 3: floor-shift out the alpha fraction, re-centre on xmean, clamp.
  assign sum_p2 = SUM_W'(prod_p2 >>> ALPHA_FRAC) + SUM_W'($signed({1'b0, xmean_p2}));
  assign sat_p2 = (DATA_WIDTH + 1)'(saturate(64'(sum_p2), DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1           <= 1'b0;
      vld_p2           <= 1'b0;
      prediction_valid <= 1'b0;
      prediction_data  <= '0;
    end else if (advance) begin
      vld_p1           <= sample_accept;
      vld_p2           <= vld_p1;
      prediction_valid <= vld_p2;
      prediction_data  <= sat_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      diff_p1  <= diff_p0;
      alpha_p1 <= alpha_held;
      xmean_p1 <= xmean_held;
      prod_p2  <= prod_p1;
      xmean_p2 <= xmean_p1;
    end
  end

endmodule

// File: tb/tb_nth_band_predictor.sv
// Self-checking bench for nth_band_predictor: vector table, spec stream with
// a drain stall, parameter withholding, random traffic and mid-block reset.
module tb_nth_band_predictor;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int BLK = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          xhat_valid = 1'b0;
  logic          xhat_ready;
  logic [DW-1:0] xhat_data = '0;
  logic          xmean_valid = 1'b0;
  logic          xmean_ready;
  logic [DW-1:0] xmean_data = '0;
  logic          xhatmean_valid = 1'b0;
  logic          xhatmean_ready;
  logic [DW-1:0] xhatmean_data = '0;
  logic          alpha_valid = 1'b0;
  logic          alpha_ready;
  logic [AW-1:0] alpha_data = '0;
  logic          prediction_valid;
  logic          prediction_ready = 1'b0;
  logic [DW:0]   prediction_data;

  always #5 clk = ~clk;

  nth_band_predictor #(.DATA_WIDTH(DW), .ALPHA_WIDTH(AW), .BLOCK_SIZE_LOG(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .xhat_valid       (xhat_valid),
    .xhat_ready       (xhat_ready),
    .xhat_data        (xhat_data),
    .xmean_valid      (xmean_valid),
    .xmean_ready      (xmean_ready),
    .xmean_data       (xmean_data),
    .xhatmean_valid   (xhatmean_valid),
    .xhatmean_ready   (xhatmean_ready),
    .xhatmean_data    (xhatmean_data),
    .alpha_valid      (alpha_valid),
    .alpha_ready      (alpha_ready),
    .alpha_data       (alpha_data),
    .prediction_valid (prediction_valid),
    .prediction_ready (prediction_ready),
    .prediction_data  (prediction_data)
  );

  typedef struct {
    int alpha;
    int xmean;
    int xhatmean;
  } pset_t;

  typedef struct {
    int alpha;
    int xmean;
    int xhatmean;
    int xhat;
    int expected;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  pset_t set_q[$];
  pset_t sets_all[$];
  int    xhat_q[$];
  int    exp_q[$];
  int    n_samples = 0;
  bit    model_mode = 1'b1;
  int    rdy_mode = 0;
  int    xhat_prob = 100;
  bit    withhold_xmean = 1'b0;
  bit    xfire = 1'b0;
  bit    prev_stall = 1'b0;
  logic [DW:0] prev_data = '0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: exact integer arithmetic, floor division by 512, clamp to 17-bit signed.
  function automatic int model(input pset_t p, input int x);
    longint prod;
    longint q;
    longint s;
    prod = longint'(x - p.xhatmean) * longint'(p.alpha);
    q = prod / 512;
    if (prod < 0 && (prod % 512) != 0) q = q - 1;
    s = q + longint'(p.xmean);
    if (s > 65535) s = 65535;
    if (s < -65536) s = -65536;
    return int'(s);
  endfunction

  task automatic step();
    int blk;
    @(negedge clk);
    alpha_valid = rst && (set_q.size() > 0);
    if (set_q.size() > 0) begin
      alpha_data    = AW'(set_q[0].alpha);
      xmean_data    = DW'(set_q[0].xmean);
      xhatmean_data = DW'(set_q[0].xhatmean);
    end
    xmean_valid    = alpha_valid && !withhold_xmean;
    xhatmean_valid = alpha_valid;
    if (!rst || xhat_q.size() == 0) xhat_valid = 1'b0;
    else if (!xhat_valid || xfire) xhat_valid = ($urandom_range(99) < xhat_prob);
    if (xhat_q.size() > 0) xhat_data = DW'(xhat_q[0]);
    case (rdy_mode)
      0:       prediction_ready = 1'b1;
      1:       prediction_ready = ($urandom_range(3) != 0);
      default: prediction_ready = 1'b0;
    endcase
    #1;
    xfire = 1'b0;
    if (rst) begin
      if (prev_stall) begin
        check("hold_valid", int'(prediction_valid), 1);
        check("hold_data", int'(prediction_data), int'(prev_data));
      end
      if (prediction_valid && prediction_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0d expected no output", int'($signed(prediction_data)));
        end else begin
          check("prediction", int'($signed(prediction_data)), exp_q[0]);
          exp_q.delete(0);
        end
      end
      if (xhat_valid && xhat_ready) begin
        xfire = 1'b1;
        if (model_mode) begin
          blk = n_samples / BLK;
          if (blk >= sets_all.size()) begin
            total++;
            bad++;
            $display("FAIL sample_without_params: got sample %0d expected at most %0d", n_samples, sets_all.size() * BLK);
          end else begin
            exp_q.push_back(model(sets_all[blk], xhat_q[0]));
          end
        end
        xhat_q.delete(0);
        n_samples++;
      end
      if (alpha_valid && alpha_ready && xmean_valid && xmean_ready && xhatmean_valid && xhatmean_ready)
        set_q.delete(0);
      prev_stall = prediction_valid && !prediction_ready;
      prev_data  = prediction_data;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic run_until(input string name, input int xhat_left, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() > 0 || xhat_q.size() > xhat_left) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d outputs pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_samples(input int target, input int budget);
    int c;
    c = 0;
    while (n_samples < target && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) begin
      total++;
      bad++;
      $display("FAIL sample_wait_timeout: got %0d samples expected %0d", n_samples, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_q.delete();
    sets_all.delete();
    xhat_q.delete();
    exp_q.delete();
    n_samples = 0;
    step();
    step();
    check("reset_prediction_valid", int'(prediction_valid), 0);
    check("reset_prediction_data", int'(prediction_data), 0);
    check("reset_xhat_ready", int'(xhat_ready), 0);
    check("reset_alpha_ready", int'(alpha_ready), 0);
    check("reset_xmean_ready", int'(xmean_ready), 0);
    check("reset_xhatmean_ready", int'(xhatmean_ready), 0);
    rst = 1'b1;
    step();
    check("idle_alpha_ready", int'(alpha_ready), 1);
    check("idle_xhat_ready", int'(xhat_ready), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[12];
    pset_t p;

    tbl[0]  = '{512,  1000,  500,   700,   1200};
    tbl[1]  = '{256,  640,   384,   256,   576};
    tbl[2]  = '{257,  896,   896,   768,   831};
    tbl[3]  = '{1023, 65535, 0,     65535, 65535};
    tbl[4]  = '{1023, 0,     65535, 0,     -65536};
    tbl[5]  = '{0,    12345, 7,     9000,  12345};
    tbl[6]  = '{1,    100,   0,     511,   100};
    tbl[7]  = '{1,    100,   1,     0,     99};
    tbl[8]  = '{512,  0,     100,   0,     -100};
    tbl[9]  = '{512,  65535, 0,     1,     65535};
    tbl[10] = '{512,  0,     65535, 0,     -65535};
    tbl[11] = '{1023, 0,     512,   0,     -1023};

    do_reset();

    // Vector table: one block of identical samples per entry, blocks back to back.
    model_mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_q.push_back('{tbl[i].alpha, tbl[i].xmean, tbl[i].xhatmean});
      for (int j = 0; j < BLK; j++) begin
        xhat_q.push_back(tbl[i].xhat);
        exp_q.push_back(tbl[i].expected);
      end
    end
    run_until("table", 0, 12 * BLK + 200);
    check("table_sets_consumed", set_q.size(), 0);

    // Incrementing stream over two blocks with a 5-cycle drain stall mid-block.
    do_reset();
    model_mode = 1'b1;
    for (int b = 0; b < 2; b++) begin
      p = '{256 + b, 640 + 256 * b, 384 + 512 * b};
      sets_all.push_back(p);
      set_q.push_back(p);
    end
    for (int n = 0; n < 2 * BLK; n++) xhat_q.push_back(256 + 2 * n);
    wait_samples(100, 200);
    rdy_mode = 2;
    repeat (5) begin
      step();
      check("stall_xhat_ready", int'(xhat_ready), 0);
      check("stall_prediction_valid", int'(prediction_valid), 1);
    end
    rdy_mode = 0;
    run_until("stream", 0, 1000);
    check("stream_samples", n_samples, 2 * BLK);

    // Withhold xmean at the block boundary.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      p = '{300 + b, 5000 + 100 * b, 4000 - 100 * b};
      sets_all.push_back(p);
      set_q.push_back(p);
    end
    for (int n = 0; n < BLK + 10; n++) xhat_q.push_back(3000 + 7 * n);
    wait_samples(1, 20);
    withhold_xmean = 1'b1;
    run_until("withhold_drain", 10, 600);
    repeat (8) begin
      step();
      check("withhold_xhat_ready", int'(xhat_ready), 0);
      check("withhold_prediction_valid", int'(prediction_valid), 0);
    end
    check("withhold_samples", n_samples, BLK);
    check("withhold_set_pending", set_q.size(), 1);
    withhold_xmean = 1'b0;
    run_until("withhold_resume", 0, 400);
    check("withhold_sets_consumed", set_q.size(), 0);

    // Random parameters, samples, bubbles and backpressure.
    do_reset();
    rdy_mode  = 1;
    xhat_prob = 70;
    for (int b = 0; b < 4; b++) begin
      p = '{int'($urandom_range(1023)), int'($urandom_range(65535)), int'($urandom_range(65535))};
      sets_all.push_back(p);
      set_q.push_back(p);
    end
    for (int n = 0; n < 4 * BLK; n++) xhat_q.push_back(int'($urandom_range(65535)));
    run_until("random", 0, 8000);
    check("random_samples", n_samples, 4 * BLK);

    // Reset mid-block with a full pipeline, then one fresh set covers exactly one block.
    rdy_mode  = 0;
    xhat_prob = 100;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      p = '{700, 20000, 30000 + b};
      sets_all.push_back(p);
      set_q.push_back(p);
    end
    for (int n = 0; n < 2 * BLK; n++) xhat_q.push_back(29000 + 3 * n);
    wait_samples(100, 200);
    do_reset();
    p = '{400, 10000, 20000};
    sets_all.push_back(p);
    set_q.push_back(p);
    for (int n = 0; n < BLK + 4; n++) xhat_q.push_back(19000 + 5 * n);
    run_until("post_reset", 4, 600);
    repeat (6) begin
      step();
      check("post_reset_block_end_xhat_ready", int'(xhat_ready), 0);
    end
    check("post_reset_samples", n_samples, BLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
